// File: rtl/ped_pkg.sv
// Shared types and constants for the pedestrian crossing controller.
package ped_pkg;

  localparam int unsigned PHASE_W = 8;
  localparam int unsigned CD_W    = 4;
  localparam int unsigned CD_SAT  = 15;
  localparam int unsigned DB_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WALK,
    FLASH,
    FAULT
  } ped_state_e;

  // Lamp pattern is legal only when exactly one vehicle lamp is lit.
  function automatic logic lamp_bad(input logic red, input logic yellow, input logic green);
    return !$onehot({red, yellow, green});
  endfunction

  // Display value for a FLASH cycle given the cycles left after it.
  function automatic logic [CD_W-1:0] flash_display(input logic [PHASE_W-1:0] remaining);
    if (remaining >= PHASE_W'(CD_SAT)) begin
      return CD_W'(CD_SAT);
    end
    return CD_W'(remaining) + CD_W'(1);
  endfunction

endpackage

// File: rtl/ped_crossing_ctrl_if.sv
// Lamp inputs, button and pedestrian lamp outputs of the crossing controller.
interface ped_crossing_ctrl_if;

  logic                     red;
  logic                     yellow;
  logic                     green;
  logic                     btn;
  logic                     walk;
  logic                     dont_walk;
  logic [ped_pkg::CD_W-1:0] countdown;
  logic                     req_pending;
  logic                     fault;

  modport master (
    output red, yellow, green, btn,
    input  walk, dont_walk, countdown, req_pending, fault
  );

  modport slave (
    input  red, yellow, green, btn,
    output walk, dont_walk, countdown, req_pending, fault
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce; press pulses once per stable high period.
module btn_debounce
  import ped_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Count consecutive high samples, holding at DB_CYCLES until a low sample re-arms.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != DB_W'(DB_CYCLES)) begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  assign press = sync2_q && (cnt_q == DB_W'(DB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: grants WALK / flashing DON'T-WALK inside vehicle red,
// and latches a safe fault state on a persistent illegal lamp pattern.
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int unsigned WALK_CYCLES  = 8,
  parameter int unsigned FLASH_CYCLES = 6,
  parameter int unsigned DB_CYCLES    = 3
) (
  input  logic                clk,
  input  logic                reset,
  ped_crossing_ctrl_if.slave  bus
);

  logic               press;
  logic               red_rise_c;
  logic               bad_c;
  logic               red_q, red_d;
  logic               bad_q, bad_d;
  ped_state_e         state_q, state_d;
  logic [PHASE_W-1:0] cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               walk_q, walk_d;
  logic               dont_walk_q, dont_walk_d;
  logic [CD_W-1:0]    countdown_q, countdown_d;
  logic               fault_q, fault_d;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn),
    .press (press)
  );

  assign red_rise_c = bus.red & ~red_q;
  assign bad_c      = lamp_bad(bus.red, bus.yellow, bus.green);

  always_comb begin
    red_d       = bus.red;
    bad_d       = bad_c;
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    walk_d      = 1'b0;
    dont_walk_d = 1'b1;
    countdown_d = '0;
    fault_d     = 1'b0;

    // Fault detection outranks abort, which outranks the normal sequence.
    if (bad_c && bad_q) begin
      state_d = FAULT;
    end else if ((state_q == WALK || state_q == FLASH) && !bus.red) begin
      state_d = req_q ? ARMED : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_q) state_d = ARMED;
        end
        ARMED: begin
          if (red_rise_c) begin
            state_d = WALK;
            cnt_d   = PHASE_W'(WALK_CYCLES - 1);
          end
        end
        WALK: begin
          if (cnt_q == '0) begin
            state_d = FLASH;
            cnt_d   = PHASE_W'(FLASH_CYCLES - 1);
          end else begin
            cnt_d = cnt_q - PHASE_W'(1);
          end
        end
        FLASH: begin
          if (cnt_q == '0) begin
            state_d = req_q ? ARMED : IDLE;
          end else begin
            cnt_d = cnt_q - PHASE_W'(1);
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end

    // Entry to WALK consumes the request; a press in the same cycle is not re-latched.
    if (state_d == FAULT) begin
      req_d = 1'b0;
    end else if (state_d == WALK && state_q != WALK) begin
      req_d = 1'b0;
    end else if (press && state_q != WALK && state_q != FAULT) begin
      req_d = 1'b1;
    end

    // Lamp outputs are decoded from the next state so they register with it.
    case (state_d)
      WALK: begin
        walk_d      = 1'b1;
        dont_walk_d = 1'b0;
      end
      FLASH: begin
        dont_walk_d = (state_q == FLASH) ? ~dont_walk_q : 1'b1;
        countdown_d = flash_display(cnt_d);
      end
      FAULT: begin
        fault_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red_q       <= 1'b0;
      bad_q       <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
      countdown_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      red_q       <= red_d;
      bad_q       <= bad_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
      countdown_q <= countdown_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.walk        = walk_q;
  assign bus.dont_walk   = dont_walk_q;
  assign bus.countdown   = countdown_q;
  assign bus.req_pending = req_q;
  assign bus.fault       = fault_q;

endmodule

// File: doc/ped_crossing_ctrl.md
# ped_crossing_ctrl

Pedestrian crossing controller sitting directly downstream of `FSM_traffic`. It consumes the vehicle `red`/`yellow`/`green` lamp outputs, takes a raw pedestrian button, and grants a timed WALK / flashing DON'T-WALK sequence only inside a vehicle red phase. It also flags illegal lamp patterns from the upstream FSM and latches into a safe fault state.

## Interface
Parameters:
- `WALK_CYCLES`, 8: solid WALK duration in clocks; legal range 1..255.
- `FLASH_CYCLES`, 6: flashing DON'T-WALK duration in clocks; legal range 1..255.
- `DB_CYCLES`, 3: consecutive synchronized-high samples required to register a press; legal range 1..15.

Ports:
- `clk`, input, 1: single clock, all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high; shared with `FSM_traffic`.
- `red`, input, 1: vehicle red lamp from `FSM_traffic`.
- `yellow`, input, 1: vehicle yellow lamp from `FSM_traffic`.
- `green`, input, 1: vehicle green lamp from `FSM_traffic`.
- `btn`, input, 1: raw, asynchronous pedestrian button.
- `walk`, output, 1: WALK lamp.
- `dont_walk`, output, 1: DON'T-WALK lamp.
- `countdown`, output, 4: remaining flash cycles, saturating at 15; 0 outside FLASH.
- `req_pending`, output, 1: a crossing request is latched.
- `fault`, output, 1: illegal lamp pattern detected; sticky until reset.

## Operation
- Reset values: `walk`=0, `dont_walk`=1, `countdown`=0, `req_pending`=0, `fault`=0, state IDLE. The synchronizer, debounce counter and `red_q` clear to 0.
- Button path: 2-flop synchronizer, then debounce. A press registers once when the synchronized level has been high for `DB_CYCLES` consecutive cycles. There is one press per high period, and it re-arms only after a low sample.
- A press sets `req_pending` in any state except WALK and FAULT. Presses during WALK are ignored. `req_pending` clears on entry to WALK.
- Red rise: `red_rise` = `red` & ~`red_q`, where `red_q` is `red` registered.
- Lamp check: `bad` = lamp pattern not exactly one-hot. If `bad` holds for 2 consecutive cycles, the block enters FAULT. A single-cycle glitch is tolerated.
- States and transitions:
  - IDLE: `dont_walk`=1. If `req_pending`, go to ARMED.
  - ARMED: `dont_walk`=1. Waits for `red_rise`, then goes to WALK. A red phase that is already in progress is never used; the block waits for the next rising edge of `red`.
  - WALK: `walk`=1, `dont_walk`=0 for `WALK_CYCLES` cycles, then FLASH.
  - FLASH: `walk`=0 for `FLASH_CYCLES` cycles. `dont_walk` is 1 on the first cycle and toggles every cycle after. `countdown` shows `FLASH_CYCLES` on the first cycle and decrements by 1 per cycle down to 1, saturating the display at 15. On exit, go to ARMED if `req_pending`, else IDLE.
  - FAULT: `walk`=0, `dont_walk`=1, `fault`=1, `req_pending` held at 0. The only exit is `reset`.
- Abort: if `red` is sampled low while in WALK or FLASH, the next state is ARMED if `req_pending`, else IDLE. `dont_walk`=1 and `walk`=0 from the next cycle.
- Priority, highest first: `reset` > fault detection > abort > normal transitions.
- Simultaneous press and `red_rise` while in IDLE: the press is latched, but that red phase is skipped and the crossing is granted on the next red rise.

## Timing
- All outputs are registered and change only after the rising edge of `clk`.
- Press latency: `btn` rising to `req_pending`=1 takes 2 (sync) + `DB_CYCLES` edges.
- Grant latency: at the first edge where `red`=1 and `red_q`=0 in ARMED, `walk` is 1 after that edge.
- WALK is exactly `WALK_CYCLES` clocks. FLASH is exactly `FLASH_CYCLES` clocks. No idle cycle separates WALK and FLASH, or FLASH and the following IDLE/ARMED.
- Fault: `fault` goes to 1 after the second consecutive edge at which `bad` is sampled.
- Reset mid-sequence: all outputs return to their reset values after the reset edge, and any latched request is lost.

## Structure
- Package `ped_pkg` holds:
  - the state enum: IDLE, ARMED, WALK, FLASH, FAULT;
  - the 8-bit phase-counter width constant;
  - the countdown saturation constant, 15.
- Sub-module `btn_debounce` contains the synchronizer, the debounce counter and the one-shot press pulse. It takes `clk`, `reset`, `btn` and outputs `press`.
- The top level contains the red-edge detector, the lamp checker, the FSM and the phase counter.

## Test plan
- Defaults, `btn` held high 5 cycles during green -> `req_pending`=1 five edges after press. On the next red rise, `walk`=1 for 8 cycles, then FLASH for 6 cycles with `countdown` 6,5,4,3,2,1 and `dont_walk` 1,0,1,0,1,0. Then IDLE with `dont_walk`=1 and `req_pending`=0.
- `btn` high for 2 cycles only -> no press registered, `req_pending` stays 0.
- Press mid-red -> current red phase ignored; `walk` rises only one edge after the following red rise.
- `red` drops at WALK cycle 3 -> `walk`=0 and `dont_walk`=1 next cycle, state IDLE. A press during FLASH of an earlier sequence instead leads to ARMED.
- Force `red`=`green`=1 for 1 cycle -> no fault. Hold it for 2 cycles -> `fault`=1, `dont_walk`=1, and further presses leave `req_pending`=0 until `reset`.
- Assert `reset` in FLASH with `req_pending`=1 -> after the reset edge: `walk`=0, `dont_walk`=1, `countdown`=0, `req_pending`=0, `fault`=0.
